// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers
// for the bypassing integer register file.
package regfile_pkg;

  localparam int REGFILE_DATA_WIDTH   = 32;
  localparam int REGFILE_NUM_REGS     = 32;
  localparam int REGFILE_NUM_RD_PORTS = 2;

  localparam int REG_ZERO = 0;

  // Source selected by one read port.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_STORE
  } rd_src_e;

  // Address width for a register count.
  function automatic int addr_width(
    input int num_regs
  );
    if (num_regs <= 2) begin
      return 1;
    end
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits
// set at issue, cleared at writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int AW       = addr_width(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic                set_hit;
  logic                clr_hit;

  assign set_hit = issue_en
                && (issue_addr != AW'(REG_ZERO));
  assign clr_hit = wr_en
                && (wr_addr != AW'(REG_ZERO));

  // Clear first, then set: a new producer
  // issuing to the register being retired wins.
  always_comb begin
    pend_nxt = pend;
    if (clr_hit) begin
      pend_nxt[wr_addr] = 1'b0;
    end
    if (set_hit) begin
      pend_nxt[issue_addr] = 1'b1;
    end
    pend_nxt[REG_ZERO] = 1'b0;
  end

  // Pending flops, wiped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign busy_vec = pend;

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: register file with async reset,
// write-to-read bypass and pending scoreboard.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH   = REGFILE_DATA_WIDTH,
  parameter  int NUM_REGS     = REGFILE_NUM_REGS,
  parameter  int NUM_RD_PORTS = REGFILE_NUM_RD_PORTS,
  localparam int AW           = addr_width(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             issue_en,
  input  logic [AW-1:0]                    issue_addr,
  input  logic [NUM_RD_PORTS*AW-1:0]       rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]          rd_pending,
  output logic [NUM_REGS-1:0]              busy_vec
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  byp_ok;

  // Bypass is held off during reset so every
  // read port shows zero while rst_n is low.
  assign byp_ok = wr_en && rst_n;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_vec   (busy_vec)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == REG_ZERO) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_flop
      logic [DATA_WIDTH-1:0] q;
      logic                  hit;

      assign hit = wr_en && (wr_addr == AW'(i));

      // Storage for one architectural register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (hit) begin
          q <= wr_data;
        end
      end

      assign mem[i] = q;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  pnd;
    rd_src_e               src;

    assign addr = rd_addr[p*AW +: AW];

    // Priority: x0, then same-cycle write, then storage.
    always_comb begin
      src = SRC_STORE;
      if (addr == AW'(REG_ZERO)) begin
        src = SRC_ZERO;
      end else if (byp_ok && (wr_addr == addr)) begin
        src = SRC_BYPASS;
      end
    end

    // Drive data and hazard flag for the chosen source.
    always_comb begin
      data = '0;
      pnd  = 1'b0;
      unique case (src)
        SRC_ZERO: begin
          data = '0;
          pnd  = 1'b0;
        end
        SRC_BYPASS: begin
          data = wr_data;
          pnd  = 1'b0;
        end
        SRC_STORE: begin
          data = mem[addr];
          pnd  = busy_vec[addr];
        end
        default: begin
          data = '0;
          pnd  = 1'b0;
        end
      endcase
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_pending[p] = pnd;
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: randomized scoreboard bench
// for default and 64x16x4 register files.
module tb_regfile_bypass;
  import regfile_pkg::*;

  typedef struct packed {
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [63:0]     wr_data;
    logic            issue_en;
    logic [4:0]      issue_addr;
    logic [3:0][4:0] rd;
  } stim_t;

  typedef struct packed {
    logic [3:0][63:0] data;
    logic [3:0]       pend;
    logic [31:0]      busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_issue_en;
  logic [4:0]  a_issue_addr;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_pending;
  logic [31:0] a_busy;

  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_issue_en;
  logic [3:0]   b_issue_addr;
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_pending;
  logic [15:0]  b_busy;

  regfile_bypass dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (a_wr_en),
    .wr_addr    (a_wr_addr),
    .wr_data    (a_wr_data),
    .issue_en   (a_issue_en),
    .issue_addr (a_issue_addr),
    .rd_addr    (a_rd_addr),
    .rd_data    (a_rd_data),
    .rd_pending (a_rd_pending),
    .busy_vec   (a_busy)
  );

  regfile_bypass #(
    .DATA_WIDTH   (64),
    .NUM_REGS     (16),
    .NUM_RD_PORTS (4)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (b_wr_en),
    .wr_addr    (b_wr_addr),
    .wr_data    (b_wr_data),
    .issue_en   (b_issue_en),
    .issue_addr (b_issue_addr),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .rd_pending (b_rd_pending),
    .busy_vec   (b_busy)
  );

  int total = 0;
  int bad   = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Architectural view: values and outstanding producers.
  logic [63:0] m_regs [2][32];
  logic        m_pend [2][32];

  function automatic exp_t predict(
    input int k, input stim_t s, input bit in_rst
  );
    exp_t e;
    int nr, np, a;
    e  = '0;
    nr = (k == 0) ? 32 : 16;
    np = (k == 0) ? 2 : 4;
    if (!in_rst) begin
      for (int p = 0; p < np; p++) begin
        a = int'(s.rd[p]);
        if (a == 0) begin
          e.data[p] = '0;
        end else if (s.wr_en && s.wr_addr == s.rd[p]) begin
          e.data[p] = s.wr_data;
        end else begin
          e.data[p] = m_regs[k][a];
          e.pend[p] = m_pend[k][a];
        end
      end
      for (int i = 0; i < nr; i++) begin
        e.busy[i] = m_pend[k][i];
      end
    end
    return e;
  endfunction

  task automatic model_commit(input int k, input stim_t s);
    if (s.wr_en && s.wr_addr != 0) begin
      m_regs[k][s.wr_addr] = s.wr_data;
      m_pend[k][s.wr_addr] = 1'b0;
    end
    if (s.issue_en && s.issue_addr != 0) begin
      m_pend[k][s.issue_addr] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = '0;
        m_pend[k][i] = 1'b0;
      end
    end
  endtask

  function automatic stim_t mk(
    input bit we, input int wa, input logic [63:0] wd,
    input bit ie, input int ia,
    input int r0, input int r1,
    input int r2 = 0, input int r3 = 0
  );
    stim_t s;
    s.wr_en      = we;
    s.wr_addr    = 5'(wa);
    s.wr_data    = wd;
    s.issue_en   = ie;
    s.issue_addr = 5'(ia);
    s.rd[0]      = 5'(r0);
    s.rd[1]      = 5'(r1);
    s.rd[2]      = 5'(r2);
    s.rd[3]      = 5'(r3);
    return s;
  endfunction

  function automatic stim_t rnd(input int k);
    stim_t s;
    int nr;
    nr = (k == 0) ? 32 : 16;
    s.wr_en      = 1'($urandom_range(0, 1));
    s.wr_addr    = 5'($urandom_range(0, nr - 1));
    s.wr_data    = {32'($urandom), 32'($urandom)};
    if (k == 0) s.wr_data[63:32] = '0;
    s.issue_en   = 1'($urandom_range(0, 1));
    s.issue_addr = 5'($urandom_range(0, nr - 1));
    for (int p = 0; p < 4; p++) begin
      if ($urandom_range(0, 3) == 0) s.rd[p] = s.wr_addr;
      else s.rd[p] = 5'($urandom_range(0, nr - 1));
    end
    if (k == 0) begin
      s.rd[2] = '0;
      s.rd[3] = '0;
    end
    return s;
  endfunction

  task automatic apply(input stim_t sa, input stim_t sb);
    a_wr_en      = sa.wr_en;
    a_wr_addr    = sa.wr_addr;
    a_wr_data    = sa.wr_data[31:0];
    a_issue_en   = sa.issue_en;
    a_issue_addr = sa.issue_addr;
    a_rd_addr    = {sa.rd[1], sa.rd[0]};
    b_wr_en      = sb.wr_en;
    b_wr_addr    = sb.wr_addr[3:0];
    b_wr_data    = sb.wr_data;
    b_issue_en   = sb.issue_en;
    b_issue_addr = sb.issue_addr[3:0];
    b_rd_addr    = {sb.rd[3][3:0], sb.rd[2][3:0],
                    sb.rd[1][3:0], sb.rd[0][3:0]};
  endtask

  // mode 0: normal, 1: reset pulse mid-cycle, 2: reset held
  task automatic cycle(
    input stim_t sa, input stim_t sb, input int mode
  );
    @(posedge clk);
    #1;
    rst_n = (mode == 2) ? 1'b0 : 1'b1;
    apply(sa, sb);
    if (mode == 0) begin
      qa.push_back(predict(0, sa, 1'b0));
      qb.push_back(predict(1, sb, 1'b0));
      model_commit(0, sa);
      model_commit(1, sb);
    end else begin
      if (mode == 1) begin
        #2;
        rst_n = 1'b0;
      end
      model_clear();
      qa.push_back(predict(0, sa, 1'b1));
      qb.push_back(predict(1, sb, 1'b1));
      if (mode == 1) begin
        @(negedge clk);
        #2;
        apply('0, '0);
        rst_n = 1'b1;
      end
    end
  endtask

  task automatic chk(
    input string nm, input int p,
    input logic [63:0] got, input logic [63:0] want
  );
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h",
               nm, p, got, want);
    end
  endtask

  exp_t ea;
  exp_t eb;

  // Monitor: outputs settle before the falling edge.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      for (int p = 0; p < 2; p++) begin
        chk("a.rd_data", p,
            {32'h0, a_rd_data[p*32 +: 32]}, ea.data[p]);
        chk("a.rd_pending", p,
            64'(a_rd_pending[p]), 64'(ea.pend[p]));
      end
      chk("a.busy_vec", 0, 64'(a_busy), 64'(ea.busy));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      for (int p = 0; p < 4; p++) begin
        chk("b.rd_data", p,
            b_rd_data[p*64 +: 64], eb.data[p]);
        chk("b.rd_pending", p,
            64'(b_rd_pending[p]), 64'(eb.pend[p]));
      end
      chk("b.busy_vec", 0,
          64'(b_busy), 64'(eb.busy[15:0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d",
             total, bad);
    $fatal(1);
  end

  stim_t z;

  initial begin
    z     = '0;
    rst_n = 1'b0;
    model_clear();
    apply(z, z);
    // reset held with arbitrary reads and writes
    cycle(mk(1, 5, 64'h77, 1, 5, 5, 31),
          mk(1, 3, 64'h99, 1, 3, 3, 15, 1, 2), 2);
    cycle(mk(0, 0, 0, 0, 0, 31, 1),
          mk(0, 0, 0, 0, 0, 15, 3, 7, 9), 2);
    // x0 is never written
    cycle(mk(1, 0, 64'hDEADBEEF, 0, 0, 0, 0), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 0, 1), z, 0);
    // write then read, neighbour stays zero
    cycle(mk(1, 5, 64'h12345678, 0, 0, 1, 2), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 5, 6), z, 0);
    // bypass on both ports
    cycle(mk(1, 7, 64'h11, 0, 0, 0, 0), z, 0);
    cycle(mk(1, 7, 64'h22, 0, 0, 7, 7), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 7, 7), z, 0);
    // scoreboard set, clear, and same-cycle collision
    cycle(mk(0, 0, 0, 1, 9, 9, 9), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 9, 0), z, 0);
    cycle(mk(1, 9, 64'h9A, 0, 0, 9, 9), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 9, 0), z, 0);
    cycle(mk(1, 9, 64'h9B, 1, 9, 9, 0), z, 0);
    cycle(mk(0, 0, 0, 0, 0, 9, 9), z, 0);
    // reset pulse drops pending state and in-flight write
    cycle(mk(1, 3, 64'hA5, 1, 4, 0, 0),
          mk(1, 2, 64'h5A5A, 1, 6, 0, 0), 0);
    cycle(mk(0, 0, 0, 0, 0, 3, 4),
          mk(0, 0, 0, 0, 0, 2, 6), 0);
    cycle(mk(1, 10, 64'hBEEF, 1, 11, 3, 4),
          mk(1, 5, 64'h1234, 0, 0, 2, 5), 1);
    cycle(mk(0, 0, 0, 0, 0, 10, 3),
          mk(0, 0, 0, 0, 0, 5, 2, 6, 0), 0);
    // wide configuration, all four ports
    cycle(z, mk(1, 15, 64'hFFFF_FFFF_0000_0001,
                0, 0, 15, 15, 15, 15), 0);
    cycle(z, mk(0, 0, 0, 1, 15, 15, 15, 15, 15), 0);
    cycle(z, mk(0, 0, 0, 0, 0, 15, 15, 15, 15), 0);
    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      cycle(rnd(0), rnd(1), (n == 150) ? 1 : 0);
    end
    @(posedge clk);
    apply(z, z);
    @(posedge clk);
    #1;
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d want=0/0",
               qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
